// File: rtl/core_pkg.sv
// Shared core constants: default datapath width, reset PC, bubble encoding and major opcodes.
package core_pkg;

    localparam int          XLEN_DEFAULT      = 32;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // RV32I major opcodes the front end and hazard logic care about.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/core_if_id_reg.sv
// Generic pipeline register carrying instr/pc/pc_plus4/valid with load, hold and flush.
// Flush wins over load; flush replaces the instruction with a bubble but keeps the PC fields.
module core_if_id_reg
    import core_pkg::*;
#(
    parameter int          XLEN      = XLEN_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (flush_i) begin
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else if (load_i) begin
            r_instr    <= instr_i;
            r_pc       <= pc_i;
            r_pc_plus4 <= pc_plus4_i;
            r_valid    <= 1'b1;
        end
    end

    assign instr_o    = r_instr;
    assign pc_o       = r_pc;
    assign pc_plus4_o = r_pc_plus4;
    assign valid_o    = r_valid;

endmodule

// File: rtl/core_if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID register feeding decode.
// Define IF_PERF_CNT_EN to build the fetch/bubble performance counters.
module core_if_stage
    import core_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_valid_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o,
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     bubble_cnt_o
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_tgt;
    logic            w_fetch;
    logic            w_bubble;

    assign w_pc_plus4     = r_pc + XLEN'(4);
    assign w_redirect_tgt = redirect_pc_i & ~XLEN'(3);

    // Redirect beats stall beats memory wait; only a clean cycle advances the PC.
    always_comb begin
        w_pc_next = r_pc;
        w_fetch   = 1'b0;
        w_bubble  = 1'b0;
        if (redirect_i) begin
            w_pc_next = w_redirect_tgt;
            w_bubble  = 1'b1;
        end else if (stall_i) begin
            w_pc_next = r_pc;
        end else if (!imem_valid_i) begin
            w_bubble  = 1'b1;
        end else begin
            w_pc_next = w_pc_plus4;
            w_fetch   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign imem_addr_o = r_pc;

    core_if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (w_fetch),
        .flush_i    (w_bubble),
        .instr_i    (imem_rdata_i),
        .pc_i       (r_pc),
        .pc_plus4_i (w_pc_plus4),
        .instr_o    (instr_o),
        .pc_o       (pc_o),
        .pc_plus4_o (pc_plus4_o),
        .valid_o    (valid_o)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_fetch) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_bubble) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o  = r_fetch_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`else
    assign fetch_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_core_if_stage.sv
// Self-checking bench for core_if_stage: directed scenarios plus randomized traffic against a reference model.
module tb_core_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ival;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fcnt;
    logic [31:0] bcnt;

    logic        rst2_n;
    logic [31:0] addr2;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic [31:0] pc42;
    logic        valid2;
    logic [31:0] fcnt2;
    logic [31:0] bcnt2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc_o;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed word at 0, an address-derived pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return {~a[15:0], a[15:0]};
    endfunction

    assign rdata  = mem_word(addr);
    assign rdata2 = mem_word(addr2);

    core_if_stage u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .imem_addr_o   (addr),
        .imem_rdata_i  (rdata),
        .imem_valid_i  (ival),
        .instr_o       (instr),
        .pc_o          (pc),
        .pc_plus4_o    (pc4),
        .valid_o       (valid),
        .fetch_cnt_o   (fcnt),
        .bubble_cnt_o  (bcnt)
    );

    core_if_stage #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk_i         (clk),
        .rst_ni        (rst2_n),
        .stall_i       (1'b0),
        .redirect_i    (1'b0),
        .redirect_pc_i (32'h0),
        .imem_addr_o   (addr2),
        .imem_rdata_i  (rdata2),
        .imem_valid_i  (1'b1),
        .instr_o       (instr2),
        .pc_o          (pc2),
        .pc_plus4_o    (pc42),
        .valid_o       (valid2),
        .fetch_cnt_o   (fcnt2),
        .bubble_cnt_o  (bcnt2)
    );

    logic [192:0] act_vec;
    assign act_vec = {addr, instr, pc, pc4, valid, fcnt, bcnt};

    function automatic void model_reset();
        m_pc     = 32'h0;
        m_instr  = 32'h0000_0013;
        m_pc_o   = 32'h0;
        m_pc4    = 32'h0;
        m_valid  = 1'b0;
        m_fetch  = 32'h0;
        m_bubble = 32'h0;
    endfunction

    // One clock edge of the fetch stage as the behavioural rules describe it.
    function automatic void model_step(input logic s, input logic r, input logic [31:0] t, input logic v);
        if (r) begin
            m_pc     = {t[31:2], 2'b00};
            m_instr  = 32'h0000_0013;
            m_valid  = 1'b0;
            m_bubble = m_bubble + 1;
        end else if (s) begin
            m_pc = m_pc;
        end else if (!v) begin
            m_instr  = 32'h0000_0013;
            m_valid  = 1'b0;
            m_bubble = m_bubble + 1;
        end else begin
            m_instr = mem_word(m_pc);
            m_pc_o  = m_pc;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_fetch = m_fetch + 1;
        end
    endfunction

    function automatic logic [192:0] exp_vec();
        logic [31:0] ef;
        logic [31:0] eb;
`ifdef IF_PERF_CNT_EN
        ef = m_fetch;
        eb = m_bubble;
`else
        ef = 32'h0;
        eb = 32'h0;
`endif
        return {m_pc, m_instr, m_pc_o, m_pc4, m_valid, ef, eb};
    endfunction

    task automatic drive_cycle(input logic s, input logic r, input logic [31:0] t, input logic v);
        stall = s;
        redir = r;
        rpc   = t;
        ival  = v;
        @(posedge clk);
        model_step(s, r, t, v);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        redir = 1'b0;
        rpc   = 32'h0;
        ival  = 1'b1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        if (act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", act_vec, exp_vec());
        end
        checks++;
        if ({addr, instr, valid} !== {32'h0, 32'h0000_0013, 1'b0}) begin
            failures++;
            $display("FAIL reset_const got=%h/%h/%b exp=0/00000013/0", addr, instr, valid);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_seq_fetch();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            if (addr !== 32'(i * 4)) begin
                failures++;
                $display("FAIL seq_addr i=%0d got=%h exp=%h", i, addr, 32'(i * 4));
            end
            checks++;
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL seq_fetch cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec());
            end
            checks++;
            if (i == 0 && {instr, pc, pc4, valid} !== {32'h00A0_0093, 32'h0, 32'h4, 1'b1}) begin
                failures++;
                $display("FAIL first_fetch got=%h/%h/%h/%b exp=00a00093/0/4/1", instr, pc, pc4, valid);
            end
            checks++;
        end
    endtask

    task automatic test_stall();
        apply_reset();
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b0, 32'h0, 1'b1);
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec());
            end
            checks++;
            if ({addr, pc, instr} !== {32'h8, 32'h4, mem_word(32'h4)}) begin
                failures++;
                $display("FAIL stall_const got=%h/%h/%h exp=8/4/%h", addr, pc, instr, mem_word(32'h4));
            end
            checks++;
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL stall_release cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec());
            end
            checks++;
            if (pc !== 32'(8 + 4 * i)) begin
                failures++;
                $display("FAIL stall_resume_pc got=%h exp=%h", pc, 32'(8 + 4 * i));
            end
            checks++;
        end
    endtask

    task automatic test_redirect_over_stall();
        drive_cycle(1'b1, 1'b1, 32'h100, 1'b1);
        if (act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL redir_stall cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec());
        end
        checks++;
        if ({addr, instr, valid} !== {32'h100, 32'h0000_0013, 1'b0}) begin
            failures++;
            $display("FAIL redir_stall_const got=%h/%h/%b exp=100/00000013/0", addr, instr, valid);
        end
        checks++;
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        if ({pc, pc4, valid} !== {32'h100, 32'h104, 1'b1}) begin
            failures++;
            $display("FAIL redir_target_pc got=%h/%h/%b exp=100/104/1", pc, pc4, valid);
        end
        checks++;
    endtask

    task automatic test_imem_wait();
        apply_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL imem_wait cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec());
            end
            checks++;
            if ({addr, valid} !== {32'h10, 1'b0}) begin
                failures++;
                $display("FAIL imem_wait_const got=%h/%b exp=10/0", addr, valid);
            end
            checks++;
        end
`ifdef IF_PERF_CNT_EN
        if (bcnt !== 32'd3) begin
            failures++;
            $display("FAIL bubble_cnt got=%0d exp=3", bcnt);
        end
`else
        if (bcnt !== 32'd0) begin
            failures++;
            $display("FAIL bubble_cnt_off got=%0d exp=0", bcnt);
        end
`endif
        checks++;
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        if ({pc, valid} !== {32'h10, 1'b1}) begin
            failures++;
            $display("FAIL imem_resume got=%h/%b exp=10/1", pc, valid);
        end
        checks++;
    endtask

    task automatic test_redirect_cases();
        logic [31:0] cur;
        drive_cycle(1'b0, 1'b1, 32'h203, 1'b1);
        if (addr !== 32'h200) begin
            failures++;
            $display("FAIL redir_align got=%h exp=200", addr);
        end
        checks++;
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cur = addr;
        drive_cycle(1'b0, 1'b1, cur, 1'b1);
        if (act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL redir_self cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec());
        end
        checks++;
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        if ({pc, valid} !== {cur, 1'b1}) begin
            failures++;
            $display("FAIL redir_self_refetch got=%h/%b exp=%h/1", pc, valid, cur);
        end
        checks++;
        drive_cycle(1'b0, 1'b1, 32'h300, 1'b0);
        if ({addr, valid} !== {32'h300, 1'b0}) begin
            failures++;
            $display("FAIL redir_wait got=%h/%b exp=300/0", addr, valid);
        end
        checks++;
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        if (act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL redir_wait_next cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec());
        end
        checks++;
    endtask

    task automatic test_pc_wrap();
        logic [31:0] ef;
`ifdef IF_PERF_CNT_EN
        ef = 32'd2;
`else
        ef = 32'd0;
`endif
        if (addr2 !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_reset_pc got=%h exp=fffffffc", addr2);
        end
        checks++;
        @(negedge clk);
        rst2_n = 1'b1;
        @(posedge clk);
        #1;
        if ({addr2, instr2, pc2, pc42, valid2} !== {32'h0, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL wrap_first got=%h/%h/%h/%h/%b exp=0/%h/fffffffc/0/1",
                     addr2, instr2, pc2, pc42, valid2, mem_word(32'hFFFF_FFFC));
        end
        checks++;
        @(posedge clk);
        #1;
        if ({instr2, pc2, pc42, fcnt2, bcnt2} !== {32'h00A0_0093, 32'h0, 32'h4, ef, 32'h0}) begin
            failures++;
            $display("FAIL wrap_second got=%h/%h/%h/%0d/%0d exp=00a00093/0/4/%0d/0",
                     instr2, pc2, pc42, fcnt2, bcnt2, ef);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 16; i++) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        if (addr !== 32'h40) begin
            failures++;
            $display("FAIL async_pre got=%h exp=40", addr);
        end
        checks++;
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        if (act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", act_vec, exp_vec());
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
        if ({pc, instr, valid} !== {32'h0, 32'h00A0_0093, 1'b1}) begin
            failures++;
            $display("FAIL async_refetch got=%h/%h/%b exp=0/00a00093/1", pc, instr, valid);
        end
        checks++;
    endtask

    task automatic test_random();
        logic        s;
        logic        r;
        logic [31:0] t;
        logic        v;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            t = $urandom;
            v = ($urandom_range(0, 4) != 0);
            drive_cycle(s, r, t, v);
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        stall  = 1'b0;
        redir  = 1'b0;
        rpc    = 32'h0;
        ival   = 1'b1;
        model_reset();
        test_reset();
        test_seq_fetch();
        test_stall();
        test_redirect_over_stall();
        test_imem_wait();
        test_redirect_cases();
        test_pc_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_if_stage.md
Name: core_if_stage

Overview:
Instruction-fetch stage that directly feeds the decode stage. Holds the program counter, drives the instruction-memory address, and computes the next PC (sequential, hold, or redirect). Owns the IF/ID pipeline register whose instr_o feeds the decode stage's instruction input. Honours the load-use stall from the hazard unit and the branch/jump redirect (flush) from EX.

Parameters:
XLEN, 32, datapath / PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) injected on flush or fetch wait

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
stall_i  input  1  hazard-unit stall; holds PC and IF/ID
redirect_i  input  1  taken branch/jump resolved in EX
redirect_pc_i  input  XLEN  redirect target
imem_addr_o  output  XLEN  instruction-memory address (= pc_q)
imem_rdata_i  input  32  instruction word, combinational read of imem_addr_o
imem_valid_i  input  1  imem_rdata_i valid this cycle (0 = memory wait)
instr_o  output  32  IF/ID instruction to decode
pc_o  output  XLEN  IF/ID PC of instr_o
pc_plus4_o  output  XLEN  IF/ID pc_o+4 (link value)
valid_o  output  1  IF/ID holds a real instruction
fetch_cnt_o  output  32  retired-fetch counter (optional feature)
bubble_cnt_o  output  32  injected-bubble counter (optional feature)

Behaviour:
- Reset (async, rst_ni=0): pc_q=RESET_PC; instr_o=NOP_INSTR; pc_o=0; pc_plus4_o=0; valid_o=0; counters=0. Deassertion: fetch from RESET_PC on the first rising edge.
- imem_addr_o = pc_q, combinational. Fetch latency is one cycle: the word fetched in cycle N appears on instr_o in cycle N+1.
- Per-edge priority (highest first):
  1. redirect_i: pc_q<=redirect_pc_i with bits[1:0] forced to 0; IF/ID<=bubble (instr_o=NOP_INSTR, valid_o=0, pc_o/pc_plus4_o unchanged). Overrides stall_i and imem_valid_i.
  2. stall_i: pc_q and the whole IF/ID register hold.
  3. !imem_valid_i: pc_q holds; IF/ID<=bubble.
  4. Otherwise: IF/ID<={imem_rdata_i, pc_q, pc_q+4, valid=1}; pc_q<=pc_q+4.
- Arithmetic: pc_q+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 with no flag.
- A redirect to the current pc_q is still a flush: exactly one bubble.
- A redirect while imem_valid_i=0 takes the target immediately and discards the pending fetch.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values asynchronously; nothing in flight survives.
- No combinational path from stall_i or redirect_i to imem_addr_o; all changes are registered.

Optional Feature:
IF_PERF_CNT_EN: when defined, fetch_cnt_o increments on every edge with case 4 (real fetch latched), and bubble_cnt_o increments on every edge with case 1 or 3. Both are 32-bit, wrap silently, and reset to 0. When undefined, both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package core_pkg: NOP_INSTR constant, RESET_PC default, XLEN default, opcode constants (OPC_LOAD=7'b0000011, OPC_BRANCH, OPC_JAL, OPC_JALR).
- One sub-module: core_if_id_reg. It holds instr/pc/pc_plus4/valid with load, hold and flush controls, and is reused by the ID/EX and later pipeline registers.

Test Plan:
- Reset then 4 cycles, imem returning 32'h00A00093 at 0x0: imem_addr_o = 0,4,8,C; instr_o = 00A00093 in cycle 1 with pc_o=0, pc_plus4_o=4, valid_o=1.
- stall_i=1 for 2 cycles at pc_q=0x8: imem_addr_o stays 0x8 and instr_o/pc_o (0x4) hold; on release, fetch resumes at 0x8 with no instruction lost or duplicated.
- redirect_i=1, redirect_pc_i=0x100 while stall_i=1: next cycle imem_addr_o=0x100, instr_o=00000013, valid_o=0; following cycle pc_o=0x100.
- imem_valid_i=0 for 3 cycles at 0x10: PC holds at 0x10 and three bubbles issue (valid_o=0); bubble_cnt_o=3 with IF_PERF_CNT_EN.
- redirect_pc_i=0x203: pc becomes 0x200. Separately, RESET_PC=0xFFFF_FFFC: second fetch at 0x0 and pc_plus4_o=0x0.
- Assert rst_ni mid-stream (pc_q=0x40, stall_i=1): outputs return to reset values within the same cycle without a clock edge; the fetch after release is at RESET_PC.
